// File: rtl/scan_index_gen_pkg.sv
// Shared definitions for the scan index generator: FSM state encoding,
// scan index width and the advance rule used by the top level.
package scan_index_gen_pkg;

  localparam int SCAN_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_t;

  // Next scan index for one advance; MSB of the result is the wrap flag.
  function automatic logic [SCAN_SEL_W:0] scan_next(
    input logic [SCAN_SEL_W-1:0] cur,
    input logic [SCAN_SEL_W-1:0] lim,
    input logic                  down
  );
    logic [SCAN_SEL_W:0] res;
    if (!down) begin
      if (cur >= lim) res = {1'b1, {SCAN_SEL_W{1'b0}}};
      else            res = {1'b0, cur + SCAN_SEL_W'(1)};
    end else begin
      if ((cur == '0) || (cur > lim)) res = {1'b1, lim};
      else                            res = {1'b0, cur - SCAN_SEL_W'(1)};
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Step-period counter for the scan index generator. Counts 0..eff_div-1
// and flags the terminal count; a count already past a freshly lowered
// eff_div-1 also counts as terminal so the step is never lost.
module scan_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] eff_div,
  output logic                  step
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic                  w_step;

  assign w_step = (r_cnt >= (eff_div - PRESCALE_W'(1)));
  assign step   = w_step;

  // Prescaler count: held at zero while cleared, restarts after each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || w_step) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/scan_index_gen.sv
// Timed scan index generator feeding a 3-to-8 decoder select input.
// Optional feature: define SCAN_BLANK_GAP_EN to insert a one-cycle blanked
// GAP state after every advance (anti-ghosting); default build has no GAP.
module scan_index_gen
  import scan_index_gen_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int SEL_W      = SCAN_SEL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic [SEL_W-1:0]      last,
  input  logic                  dir,
  output logic [SEL_W-1:0]      sel,
  output logic                  blank,
  output logic                  tick,
  output logic                  wrap
);

  scan_state_t           r_state;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_blank;
  logic                  r_tick;
  logic                  r_wrap;

  logic [PRESCALE_W-1:0] w_eff_div;
  logic                  w_clr;
  logic                  w_step;
  logic [SEL_W:0]        w_nxt;

  // A programmed divide of zero behaves as one clock per step.
  assign w_eff_div = (div == '0) ? PRESCALE_W'(1) : div;
  // Prescaler only runs while scanning and enabled; cleared otherwise.
  assign w_clr     = (r_state != ST_RUN) || !en;
  assign w_nxt     = scan_next(r_sel, last, dir);

  scan_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .eff_div (w_eff_div),
    .step    (w_step)
  );

  // Scan FSM with registered sel, blank, tick and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_blank <= 1'b1;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state <= ST_RUN;
            r_blank <= 1'b0;
          end else begin
            r_blank <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!en) begin
            r_state <= ST_IDLE;
            r_blank <= 1'b1;
          end else if (w_step) begin
            r_sel  <= w_nxt[SEL_W-1:0];
            r_tick <= 1'b1;
            r_wrap <= w_nxt[SEL_W];
`ifdef SCAN_BLANK_GAP_EN
            r_state <= ST_GAP;
            r_blank <= 1'b1;
`endif
          end
        end
        ST_GAP: begin
          if (!en) begin
            r_state <= ST_IDLE;
            r_blank <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_blank <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_blank <= 1'b1;
        end
      endcase
    end
  end

  assign sel   = r_sel;
  assign blank = r_blank;
  assign tick  = r_tick;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_scan_index_gen.sv
// Self-checking bench for scan_index_gen. A behavioural model tracks
// "enabled / cycles into the current step period / gap pending" and applies
// the advance rules directly; honours SCAN_BLANK_GAP_EN like the design.
module tb_scan_index_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] div;
  logic [2:0]  last;
  logic        dir;
  logic [2:0]  sel;
  logic        blank;
  logic        tick;
  logic        wrap;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit m_active;
  int m_elapsed;
  bit m_gap_pending;
  int m_sel;
  bit m_tick, m_wrap, m_blank;

`ifdef SCAN_BLANK_GAP_EN
  localparam bit GAP_BUILD = 1'b1;
`else
  localparam bit GAP_BUILD = 1'b0;
`endif

  scan_index_gen #(.PRESCALE_W(16), .SEL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .div   (div),
    .last  (last),
    .dir   (dir),
    .sel   (sel),
    .blank (blank),
    .tick  (tick),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 0; m_elapsed = 0; m_gap_pending = 0;
    m_sel = 0; m_tick = 0; m_wrap = 0; m_blank = 1;
  endtask

  // One clock edge of the behavioural model, using the inputs seen at the edge.
  task automatic model_step();
    int period;
    int lim;
    m_tick = 0;
    m_wrap = 0;
    lim    = int'(last);
    period = (div == 0) ? 1 : int'(div);
    if (!en) begin
      m_active = 0; m_elapsed = 0; m_gap_pending = 0; m_blank = 1;
    end else if (!m_active) begin
      m_active = 1; m_elapsed = 0; m_blank = 0;
    end else if (m_gap_pending) begin
      m_gap_pending = 0; m_elapsed = 0; m_blank = 0;
    end else if (m_elapsed + 1 >= period) begin
      m_tick = 1;
      m_elapsed = 0;
      if (dir == 1'b0) begin
        if (m_sel >= lim) begin m_sel = 0; m_wrap = 1; end
        else m_sel = m_sel + 1;
      end else begin
        if (m_sel == 0 || m_sel > lim) begin m_sel = lim; m_wrap = 1; end
        else m_sel = m_sel - 1;
      end
      if (GAP_BUILD) begin m_gap_pending = 1; m_blank = 1; end
      else m_blank = 0;
    end else begin
      m_elapsed = m_elapsed + 1;
      m_blank = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 0; div = 16'd1; last = 3'd7; dir = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({sel, blank, tick, wrap} !== {3'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset sel=%0d blank=%0b tick=%0b wrap=%0b required sel=0 blank=1 tick=0 wrap=0",
               sel, blank, tick, wrap);
    else n_pass++;
  endtask

  task automatic test_up_div4();
    int wraps;
    int ticks;
    do_reset();
    en = 1; div = 16'd4; last = 3'd7; dir = 0;
    wraps = 0; ticks = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); model_step(); #1;
      if (tick) ticks++;
      if (wrap) begin
        wraps++;
        n_checks++;
        if (sel !== 3'd0) $display("FAIL up_wrap_to_zero sel=%0d required 0", sel);
        else n_pass++;
      end
      n_checks++;
      if ({sel, tick, wrap, blank} !== {3'(m_sel), m_tick, m_wrap, m_blank})
        $display("FAIL up_div4 cyc=%0d got sel=%0d t=%0b w=%0b b=%0b required sel=%0d t=%0b w=%0b b=%0b",
                 c, sel, tick, wrap, blank, m_sel, m_tick, m_wrap, m_blank);
      else n_pass++;
    end
    n_checks++;
    if (wraps * 8 > ticks || ticks - wraps * 8 >= 8 || wraps == 0)
      $display("FAIL up_wrap_rate wraps=%0d ticks=%0d required one wrap per 8 ticks", wraps, ticks);
    else n_pass++;
  endtask

  task automatic test_down_div1();
    int seq[$];
    int exp_seq[7] = '{5, 4, 3, 2, 1, 0, 5};
    do_reset();
    en = 1; div = 16'd1; last = 3'd5; dir = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); model_step(); #1;
      if (tick) begin
        seq.push_back(int'(sel));
        if (seq.size() == 1 || seq.size() == 7) begin
          n_checks++;
          if (wrap !== 1'b1) $display("FAIL down_wrap idx=%0d wrap=%0b required 1", seq.size(), wrap);
          else n_pass++;
        end
      end
      n_checks++;
      if ({sel, tick, wrap, blank} !== {3'(m_sel), m_tick, m_wrap, m_blank})
        $display("FAIL down_div1 cyc=%0d got sel=%0d t=%0b w=%0b b=%0b required sel=%0d t=%0b w=%0b b=%0b",
                 c, sel, tick, wrap, blank, m_sel, m_tick, m_wrap, m_blank);
      else n_pass++;
    end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (i >= seq.size() || seq[i] != exp_seq[i])
        $display("FAIL down_sequence idx=%0d got %0d required %0d", i,
                 (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_last_shrink();
    bit seen;
    do_reset();
    en = 1; div = 16'd1; last = 3'd7; dir = 0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); model_step(); #1;
      if (sel == 3'd6 && tick) seen = 1;
    end
    n_checks++;
    if (!seen) $display("FAIL shrink_reach6 sel=%0d required 6 within bound", sel);
    else n_pass++;
    last = 3'd3;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); model_step(); #1;
      if (tick) seen = 1;
    end
    n_checks++;
    if (!seen || sel !== 3'd0 || wrap !== 1'b1)
      $display("FAIL shrink_wrap sel=%0d wrap=%0b required sel=0 wrap=1", sel, wrap);
    else n_pass++;
  endtask

  task automatic test_div0_like_div1();
    do_reset();
    en = 1; last = 3'd4; dir = 0; div = 16'd0;
    for (int c = 0; c < 40; c++) begin
      div = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'd1;
      dir = 1'($urandom_range(0, 1));
      @(posedge clk); model_step(); #1;
      n_checks++;
      if ({sel, tick, wrap, blank} !== {3'(m_sel), m_tick, m_wrap, m_blank})
        $display("FAIL div0 cyc=%0d got sel=%0d t=%0b w=%0b b=%0b required sel=%0d t=%0b w=%0b b=%0b",
                 c, sel, tick, wrap, blank, m_sel, m_tick, m_wrap, m_blank);
      else n_pass++;
    end
  endtask

  task automatic test_en_drop();
    int lat;
    bit got;
    do_reset();
    en = 1; div = 16'd5; last = 3'd7; dir = 0;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); model_step(); #1;
    end
    en = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); model_step(); #1;
      n_checks++;
      if ({sel, tick, wrap, blank} !== {3'(m_sel), 1'b0, 1'b0, 1'b1})
        $display("FAIL en_drop cyc=%0d got sel=%0d t=%0b w=%0b b=%0b required sel=%0d t=0 w=0 b=1",
                 c, sel, tick, wrap, blank, m_sel);
      else n_pass++;
    end
    en = 1;
    lat = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); model_step(); #1;
      lat++;
      if (tick) got = 1;
    end
    n_checks++;
    if (!got || lat != 6)
      $display("FAIL en_restart_latency got %0d edges required 6", lat);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1; div = 16'd2; last = 3'd7; dir = 0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); model_step(); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sel, blank, tick, wrap} !== {3'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL async_reset sel=%0d blank=%0b tick=%0b wrap=%0b required sel=0 blank=1 tick=0 wrap=0",
               sel, blank, tick, wrap);
    else n_pass++;
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({sel, blank, tick, wrap} !== {3'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL async_reset_hold sel=%0d blank=%0b tick=%0b wrap=%0b required sel=0 blank=1 tick=0 wrap=0",
               sel, blank, tick, wrap);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_gap_period();
    int t_prev;
    int periods_bad;
    int blank_bad;
    int ntick;
    do_reset();
    en = 1; div = 16'd3; last = 3'd7; dir = 0;
    t_prev = -1; periods_bad = 0; blank_bad = 0; ntick = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); model_step(); #1;
      if (c > 0 && blank !== (GAP_BUILD && tick)) blank_bad++;
      if (tick) begin
        if (t_prev >= 0 && (c - t_prev) != (GAP_BUILD ? 4 : 3)) periods_bad++;
        t_prev = c;
        ntick++;
      end
    end
    n_checks++;
    if (periods_bad != 0 || ntick < 5)
      $display("FAIL gap_period bad=%0d ticks=%0d required period %0d", periods_bad, ntick, GAP_BUILD ? 4 : 3);
    else n_pass++;
    n_checks++;
    if (blank_bad != 0)
      $display("FAIL gap_blank bad_cycles=%0d required 0", blank_bad);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) div = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) last = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      @(posedge clk); model_step(); #1;
      n_checks++;
      if ({sel, tick, wrap, blank} !== {3'(m_sel), m_tick, m_wrap, m_blank})
        $display("FAIL random cyc=%0d got sel=%0d t=%0b w=%0b b=%0b required sel=%0d t=%0b w=%0b b=%0b",
                 c, sel, tick, wrap, blank, m_sel, m_tick, m_wrap, m_blank);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 0; div = 16'd1; last = 3'd7; dir = 0;
    model_reset();
    test_reset();
    test_up_div4();
    test_down_div1();
    test_last_shrink();
    test_div0_like_div1();
    test_en_drop();
    test_async_reset();
    test_gap_period();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
